// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared timing constants and helpers for the VGA timing generator.
//   - Default 640x480@60 Hz timing (25 MHz pixel rate).
//   - H_TOTAL / V_TOTAL derivation helper.
//   - 10-bit coordinate type used for both counters.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    // Half-open window test: lo <= v < hi.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay
// Delays the {hsync, vsync} pair by DLY clk cycles (independent of pix_ce)
// so the connector pins can be re-aligned with downstream pixel pipelines.
//   clk      in   system clock
//   rst      in   asynchronous active-high reset; fills the line with IDLE
//   sync_in  in   [1] hsync, [0] vsync
//   sync_out out  sync_in delayed DLY clk (DLY=0: combinational pass-through)
module vga_sync_delay #(
    parameter int unsigned DLY  = 1,
    parameter logic        IDLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sync_in,
    output logic [1:0] sync_out
);

    generate
        if (DLY == 0) begin : g_pass
            assign sync_out = sync_in;
        end else begin : g_dly
            logic [1:0] stage_d [DLY];
            logic [1:0] stage_q [DLY];

            // Shift the pair one stage per clk.
            always_comb begin
                stage_d[0] = sync_in;
                for (int i = 1; i < int'(DLY); i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers; reset loads the inactive level so no pulse
            // fragment can emerge after reset release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(DLY); i++) begin
                        stage_q[i] <= {IDLE, IDLE};
                    end
                end else begin
                    for (int i = 0; i < int'(DLY); i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign sync_out = stage_q[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator: horizontal/vertical counters, display enable,
// sync pulses and line/frame strobes, all registered and mutually aligned.
// Optional feature macro: VGA_FRAME_CNT_EN (builds a 16-bit frame counter;
// when undefined frame_cnt is tied to 0).
//   clk          in   system clock (single domain)
//   rst          in   asynchronous active-high reset
//   pix_ce       in   pixel clock enable; counters advance only when high
//   x, y         out  current hcnt / vcnt (10 bits each)
//   de           out  high inside the active area
//   hsync, vsync out  syncs aligned with x/y/de, active level SYNC_POL
//   hsync_pin,
//   vsync_pin    out  syncs delayed by SYNC_DLY clk for the connector
//   line_start   out  one-clk strobe when hcnt first shows 0
//   frame_start  out  one-clk strobe when (hcnt,vcnt) first shows (0,0)
//   frame_cnt    out  frame counter (0 unless VGA_FRAME_CNT_EN)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned SYNC_DLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        hsync_pin,
    output logic        vsync_pin,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    coord_t hcnt_d, hcnt_q;
    coord_t vcnt_d, vcnt_q;
    logic   de_d, de_q;
    logic   hsync_d, hsync_q;
    logic   vsync_d, vsync_q;
    logic   line_start_d, line_start_q;
    logic   frame_start_d, frame_start_q;
    logic [1:0] pin_s;

    // Next-state: advance the raster position and derive every aligned output
    // from the *next* position, so all registered outputs describe the same pixel.
    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        de_d          = de_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_ce) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 10'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 10'd0;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
                vcnt_d = vcnt_q;
            end
            de_d          = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
            hsync_d       = in_window(hcnt_d, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
            vsync_d       = in_window(vcnt_d, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
            line_start_d  = (hcnt_d == 10'd0);
            frame_start_d = (hcnt_d == 10'd0) && (vcnt_d == 10'd0);
        end else begin
            // Hold position and levels; strobes stay low while paused.
            hcnt_d        = hcnt_q;
            vcnt_d        = vcnt_q;
            line_start_d  = 1'b0;
            frame_start_d = 1'b0;
        end
    end

    // Timing state registers. Reset parks the position on the last pixel of the
    // frame so the first enabled edge lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q        <= H_LAST;
            vcnt_q        <= V_LAST;
            de_q          <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_d, frame_cnt_q;

    // Count frames; the value shown alongside frame_start already includes
    // that frame. Wraps naturally at 16 bits.
    always_comb begin
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

    vga_sync_delay #(
        .DLY  (SYNC_DLY),
        .IDLE (~SYNC_POL)
    ) u_sync_delay (
        .clk      (clk),
        .rst      (rst),
        .sync_in  ({hsync_q, vsync_q}),
        .sync_out (pin_s)
    );

    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hsync_pin   = pin_s[1];
    assign vsync_pin   = pin_s[0];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
